// File: rtl/rob_commit_pkg.sv
// rob_commit_pkg: sizes, ROB entry layout and commit-bus record shared by the ROB files.
package rob_commit_pkg;
    localparam int ROB_SIZE     = 18;
    localparam int ROB_IDX_SIZE = $clog2(ROB_SIZE);
    localparam int REG_SIZE     = 64;
    localparam int GPR_COUNT    = 32;
    localparam int GPR_IDX_SIZE = $clog2(GPR_COUNT);
    localparam int CNT_SIZE     = ROB_IDX_SIZE + 1;

    typedef logic [ROB_IDX_SIZE-1:0] rob_idx_t;
    typedef logic [GPR_IDX_SIZE-1:0] gpr_idx_t;

    localparam rob_idx_t ROB_LAST = rob_idx_t'(ROB_SIZE - 1);

    typedef struct packed {
        logic                valid;
        logic                done;
        logic                writes_gpr;
        gpr_idx_t            gpr_idx;
        logic [REG_SIZE-1:0] value;
        logic [3:0]          nzcv;
        logic                set_nzcv;
    } rob_entry_t;

    typedef struct packed {
        logic                valid;
        rob_idx_t            rob_index;
        logic                writes_gpr;
        gpr_idx_t            gpr_idx;
        logic [REG_SIZE-1:0] value;
        logic                set_nzcv;
        logic [3:0]          nzcv;
    } commit_bus_t;
endpackage

// File: rtl/rob_commit_if.sv
// rob_commit_if: dispatch, writeback, operand-read and commit signals of the ROB.
// in_flush exists only when ROB_FLUSH_EN is defined.
interface rob_commit_if;
    import rob_commit_pkg::*;
`ifdef ROB_FLUSH_EN
    logic                in_flush;
`endif
    logic                in_alloc_valid;
    logic                in_alloc_writes_gpr;
    gpr_idx_t            in_alloc_gpr_idx;
    logic                in_alloc_set_nzcv;
    logic                out_alloc_ready;
    rob_idx_t            out_next_free_index;
    logic                in_wb_valid;
    rob_idx_t            in_wb_rob_index;
    logic [REG_SIZE-1:0] in_wb_value;
    logic [3:0]          in_wb_nzcv;
    rob_idx_t            in_rd1_index;
    rob_idx_t            in_rd2_index;
    logic                out_rd1_ready;
    logic                out_rd2_ready;
    logic [REG_SIZE-1:0] out_rd1_value;
    logic [REG_SIZE-1:0] out_rd2_value;
    logic                out_commit_valid;
    rob_idx_t            out_commit_rob_index;
    logic                out_commit_writes_gpr;
    gpr_idx_t            out_commit_gpr_idx;
    logic [REG_SIZE-1:0] out_commit_value;
    logic                out_commit_set_nzcv;
    logic [3:0]          out_commit_nzcv;
    logic [CNT_SIZE-1:0] out_count;
    logic                out_empty;
    logic                out_full;

    modport slave (
`ifdef ROB_FLUSH_EN
        input  in_flush,
`endif
        input  in_alloc_valid, in_alloc_writes_gpr, in_alloc_gpr_idx, in_alloc_set_nzcv,
        input  in_wb_valid, in_wb_rob_index, in_wb_value, in_wb_nzcv, in_rd1_index, in_rd2_index,
        output out_alloc_ready, out_next_free_index, out_rd1_ready, out_rd2_ready,
        output out_rd1_value, out_rd2_value, out_commit_valid, out_commit_rob_index,
        output out_commit_writes_gpr, out_commit_gpr_idx, out_commit_value,
        output out_commit_set_nzcv, out_commit_nzcv, out_count, out_empty, out_full
    );

    modport master (
`ifdef ROB_FLUSH_EN
        output in_flush,
`endif
        output in_alloc_valid, in_alloc_writes_gpr, in_alloc_gpr_idx, in_alloc_set_nzcv,
        output in_wb_valid, in_wb_rob_index, in_wb_value, in_wb_nzcv, in_rd1_index, in_rd2_index,
        input  out_alloc_ready, out_next_free_index, out_rd1_ready, out_rd2_ready,
        input  out_rd1_value, out_rd2_value, out_commit_valid, out_commit_rob_index,
        input  out_commit_writes_gpr, out_commit_gpr_idx, out_commit_value,
        input  out_commit_set_nzcv, out_commit_nzcv, out_count, out_empty, out_full
    );
endinterface

// File: rtl/rob_ptr.sv
// rob_ptr: modulo-ROB_SIZE pointer register with increment and synchronous clear.
module rob_ptr
    import rob_commit_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_n_i,
    input  logic     inc_i,
    input  logic     clr_i,
    output rob_idx_t ptr_o
);
    rob_idx_t ptr_q, ptr_d;

    // ROB_SIZE need not be a power of two, so wrap explicitly
    assign ptr_d = clr_i ? '0 : !inc_i ? ptr_q : (ptr_q == ROB_LAST) ? '0 : ptr_q + 1'b1;
    assign ptr_o = ptr_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end
endmodule

// File: rtl/rob_commit.sv
// rob_commit: reorder buffer with out-of-order writeback and one in-order commit per cycle.
// Defining ROB_FLUSH_EN adds in_flush, which empties the buffer at the next edge.
module rob_commit
    import rob_commit_pkg::*;
(
    input logic         in_clk,
    input logic         in_rst_n,
    rob_commit_if.slave rob
);
    rob_entry_t          ent_q [ROB_SIZE];
    rob_entry_t          ent_d [ROB_SIZE];
    logic [CNT_SIZE-1:0] count_q, count_d;
    commit_bus_t         commit_q, commit_d;
    rob_idx_t            head, tail;
    rob_entry_t          head_ent;
    logic                flush, full, alloc, commit, wb_hit;
    logic                rd1_ok, rd2_ok, rd1_fwd, rd2_fwd;

`ifdef ROB_FLUSH_EN
    assign flush = rob.in_flush;
`else
    assign flush = 1'b0;
`endif

    // Free space comes only from the registered count, never from a same-cycle commit
    assign full     = count_q == CNT_SIZE'(ROB_SIZE);
    assign alloc    = rob.in_alloc_valid && !full;
    assign head_ent = ent_q[head];
    assign commit   = head_ent.valid && head_ent.done;
    assign wb_hit   = rob.in_wb_valid && rob.in_wb_rob_index <= ROB_LAST
                      && ent_q[rob.in_wb_rob_index].valid && !ent_q[rob.in_wb_rob_index].done;

    rob_ptr u_head (.clk_i(in_clk), .rst_n_i(in_rst_n), .inc_i(commit), .clr_i(flush), .ptr_o(head));
    rob_ptr u_tail (.clk_i(in_clk), .rst_n_i(in_rst_n), .inc_i(alloc),  .clr_i(flush), .ptr_o(tail));

    always_comb begin
        ent_d = ent_q;
        if (commit) ent_d[head] = '0;
        if (wb_hit) begin
            ent_d[rob.in_wb_rob_index].done  = 1'b1;
            ent_d[rob.in_wb_rob_index].value = rob.in_wb_value;
            ent_d[rob.in_wb_rob_index].nzcv  = rob.in_wb_nzcv;
        end
        if (alloc) ent_d[tail] = '{valid: 1'b1, done: 1'b0, writes_gpr: rob.in_alloc_writes_gpr,
                                   gpr_idx: rob.in_alloc_gpr_idx, value: '0, nzcv: '0,
                                   set_nzcv: rob.in_alloc_set_nzcv};
        if (flush) ent_d = '{default: rob_entry_t'('0)};
    end

    assign count_d  = flush ? '0 : count_q + CNT_SIZE'(alloc) - CNT_SIZE'(commit);
    assign commit_d = (commit && !flush) ? '{valid: 1'b1, rob_index: head, writes_gpr: head_ent.writes_gpr,
                                              gpr_idx: head_ent.gpr_idx, value: head_ent.value,
                                              set_nzcv: head_ent.set_nzcv, nzcv: head_ent.nzcv} : '0;

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            ent_q    <= '{default: rob_entry_t'('0)};
            count_q  <= '0;
            commit_q <= '0;
        end else begin
            ent_q    <= ent_d;
            count_q  <= count_d;
            commit_q <= commit_d;
        end
    end

    // Operand reads forward a same-cycle writeback to a pending entry
    always_comb begin
        rd1_ok            = rob.in_rd1_index <= ROB_LAST && ent_q[rob.in_rd1_index].valid;
        rd2_ok            = rob.in_rd2_index <= ROB_LAST && ent_q[rob.in_rd2_index].valid;
        rd1_fwd           = rd1_ok && wb_hit && rob.in_wb_rob_index == rob.in_rd1_index;
        rd2_fwd           = rd2_ok && wb_hit && rob.in_wb_rob_index == rob.in_rd2_index;
        rob.out_rd1_ready = rd1_ok && (ent_q[rob.in_rd1_index].done || rd1_fwd);
        rob.out_rd2_ready = rd2_ok && (ent_q[rob.in_rd2_index].done || rd2_fwd);
        rob.out_rd1_value = !rd1_ok ? '0 : rd1_fwd ? rob.in_wb_value : ent_q[rob.in_rd1_index].value;
        rob.out_rd2_value = !rd2_ok ? '0 : rd2_fwd ? rob.in_wb_value : ent_q[rob.in_rd2_index].value;
    end

    assign rob.out_alloc_ready       = !full;
    assign rob.out_full              = full;
    assign rob.out_empty             = count_q == '0;
    assign rob.out_count             = count_q;
    assign rob.out_next_free_index   = tail;
    assign rob.out_commit_valid      = commit_q.valid;
    assign rob.out_commit_rob_index  = commit_q.rob_index;
    assign rob.out_commit_writes_gpr = commit_q.writes_gpr;
    assign rob.out_commit_gpr_idx    = commit_q.gpr_idx;
    assign rob.out_commit_value      = commit_q.value;
    assign rob.out_commit_set_nzcv   = commit_q.set_nzcv;
    assign rob.out_commit_nzcv       = commit_q.nzcv;
endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed and randomized checks of rob_commit against a queue-based model.
module tb_rob_commit;
    import rob_commit_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rob_commit_if bus();
    rob_commit dut (.in_clk(clk), .in_rst_n(rst_n), .rob(bus));

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Program-order queue of in-flight tags plus per-tag contents
    int          q[$];
    int          nxt;
    bit          m_valid [ROB_SIZE];
    bit          m_done  [ROB_SIZE];
    logic [63:0] m_val   [ROB_SIZE];
    logic [3:0]  m_nzcv  [ROB_SIZE];
    bit          m_wg    [ROB_SIZE];
    int          m_gi    [ROB_SIZE];
    bit          m_sn    [ROB_SIZE];
    bit          e_cv, e_wg, e_sn;
    int          e_ci, e_gi;
    logic [63:0] e_val;
    logic [3:0]  e_nz;

    task automatic model_clear();
        q.delete();
        nxt = 0;
        e_cv = 0;
        for (int i = 0; i < ROB_SIZE; i++) begin
            m_valid[i] = 0;
            m_done[i] = 0;
            m_val[i] = '0;
        end
    endtask

    task automatic rd_check(input string tag, input int r, input bit wv, input int wi,
                            input logic [63:0] wval, input logic rdy, input logic [63:0] val);
        bit ok, fwd;
        ok  = r < ROB_SIZE && m_valid[r];
        fwd = ok && wv && wi == r && !m_done[r];
        check({tag, "_ready"}, rdy, ok && (m_done[r] || fwd));
        check({tag, "_value"}, val, !ok ? 64'd0 : fwd ? wval : m_val[r]);
    endtask

    // One clock: drive at negedge, check combinational outputs, step model, check registered outputs
    task automatic cycle(input bit av, input bit awg, input int agi, input bit asn,
                         input bit wv, input int wi, input logic [63:0] wval, input logic [3:0] wn,
                         input int r1, input int r2, input bit fl);
        bit commit, alloc, hit;
        int h;
        bus.in_alloc_valid      = av;
        bus.in_alloc_writes_gpr = awg;
        bus.in_alloc_gpr_idx    = gpr_idx_t'(agi);
        bus.in_alloc_set_nzcv   = asn;
        bus.in_wb_valid         = wv;
        bus.in_wb_rob_index     = rob_idx_t'(wi);
        bus.in_wb_value         = wval;
        bus.in_wb_nzcv          = wn;
        bus.in_rd1_index        = rob_idx_t'(r1);
        bus.in_rd2_index        = rob_idx_t'(r2);
`ifdef ROB_FLUSH_EN
        bus.in_flush            = fl;
`endif
        #1;
        check("count", bus.out_count, q.size());
        check("alloc_ready", bus.out_alloc_ready, q.size() < ROB_SIZE);
        check("full", bus.out_full, q.size() == ROB_SIZE);
        check("empty", bus.out_empty, q.size() == 0);
        check("next_free", bus.out_next_free_index, nxt);
        rd_check("rd1", r1, wv, wi, wval, bus.out_rd1_ready, bus.out_rd1_value);
        rd_check("rd2", r2, wv, wi, wval, bus.out_rd2_ready, bus.out_rd2_value);
        commit = q.size() > 0 && m_done[q[0]];
        alloc  = av && q.size() < ROB_SIZE;
        hit    = wv && wi < ROB_SIZE && m_valid[wi] && !m_done[wi];
        e_cv   = commit;
        if (commit) begin
            h = q.pop_front();
            e_ci = h; e_wg = m_wg[h]; e_gi = m_gi[h]; e_val = m_val[h]; e_sn = m_sn[h]; e_nz = m_nzcv[h];
            m_valid[h] = 0; m_done[h] = 0; m_val[h] = '0;
        end
        if (hit) begin
            m_done[wi] = 1; m_val[wi] = wval; m_nzcv[wi] = wn;
        end
        if (alloc) begin
            m_valid[nxt] = 1; m_done[nxt] = 0; m_val[nxt] = '0; m_nzcv[nxt] = '0;
            m_wg[nxt] = awg; m_gi[nxt] = agi; m_sn[nxt] = asn;
            q.push_back(nxt);
            nxt = (nxt + 1) % ROB_SIZE;
        end
`ifdef ROB_FLUSH_EN
        if (fl) model_clear();
`endif
        @(posedge clk);
        @(negedge clk);
        check("commit_valid", bus.out_commit_valid, e_cv);
        if (e_cv) begin
            check("commit_index", bus.out_commit_rob_index, e_ci);
            check("commit_wg", bus.out_commit_writes_gpr, e_wg);
            check("commit_gpr", bus.out_commit_gpr_idx, e_gi);
            check("commit_value", bus.out_commit_value, e_val);
            check("commit_sn", bus.out_commit_set_nzcv, e_sn);
            check("commit_nzcv", bus.out_commit_nzcv, e_nz);
        end
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, '0, '0, 0, 1, 0);
    endtask

    task automatic alloc_gpr(input int g);
        cycle(1, 1, g, g[0], 0, 0, '0, '0, 0, 1, 0);
    endtask

    task automatic wb(input int t, input logic [63:0] v);
        cycle(0, 0, 0, 0, 1, t, v, v[3:0], t, 0, 0);
    endtask

    task automatic rand_cycle();
        int pend[$];
        bit wv;
        int wi, r1, r2;
        pend.delete();
        foreach (q[i]) if (!m_done[q[i]]) pend.push_back(q[i]);
        if (pend.size() > 0 && $urandom_range(0, 9) < 7) begin
            wv = 1;
            wi = pend[$urandom_range(0, pend.size() - 1)];
        end else begin
            wv = 1'($urandom_range(0, 1));
            wi = $urandom_range(0, 31);
        end
        r1 = (wv && $urandom_range(0, 1) == 1) ? wi : $urandom_range(0, 31);
        r2 = $urandom_range(0, ROB_SIZE - 1);
        cycle($urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)), $urandom_range(0, GPR_COUNT - 1),
              1'($urandom_range(0, 1)), wv, wi, {$urandom, $urandom}, 4'($urandom_range(0, 15)), r1, r2, 0);
    endtask

    initial begin
        bus.in_alloc_valid = 0; bus.in_alloc_writes_gpr = 0; bus.in_alloc_gpr_idx = '0;
        bus.in_alloc_set_nzcv = 0; bus.in_wb_valid = 0; bus.in_wb_rob_index = '0;
        bus.in_wb_value = '0; bus.in_wb_nzcv = '0; bus.in_rd1_index = '0; bus.in_rd2_index = '0;
`ifdef ROB_FLUSH_EN
        bus.in_flush = 0;
`endif
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_count", bus.out_count, 0);
        check("rst_empty", bus.out_empty, 1);
        check("rst_full", bus.out_full, 0);
        check("rst_ready", bus.out_alloc_ready, 1);
        check("rst_next_free", bus.out_next_free_index, 0);
        check("rst_commit_valid", bus.out_commit_valid, 0);
        @(negedge clk);

        alloc_gpr(1); alloc_gpr(2); alloc_gpr(3);
        check("three_count", bus.out_count, 3);
        wb(2, 64'h22);
        wb(0, 64'h11);
        idle();
        check("first_commit_gpr", bus.out_commit_gpr_idx, 1);
        check("first_commit_value", bus.out_commit_value, 64'h11);
        idle(); idle();
        wb(1, 64'h33);
        idle();
        check("second_commit_index", bus.out_commit_rob_index, 1);
        idle();
        check("third_commit_index", bus.out_commit_rob_index, 2);
        repeat (3) idle();

        repeat (ROB_SIZE + 1) alloc_gpr($urandom_range(0, GPR_COUNT - 1));
        check("fill_full", bus.out_full, 1);
        check("fill_ready", bus.out_alloc_ready, 0);
        check("fill_count", bus.out_count, ROB_SIZE);
        cycle(0, 0, 0, 0, 1, 4, 64'hABCD_0004, 4'h5, 4, 4, 0);
        while (q.size() > 0) rand_cycle();

        // Steady allocate+writeback: tail wraps while count stays small
        for (int i = 0; i < 3 * ROB_SIZE; i++)
            cycle(1, 1, i % GPR_COUNT, 0, q.size() > 0, q.size() > 0 ? q[$] : 0,
                  64'(i), 4'(i), nxt, 0, 0);
        check("steady_count_bound", bus.out_count <= 2, 1);

        repeat (2000) rand_cycle();

        repeat (4) alloc_gpr(7);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_count", bus.out_count, 0);
        check("async_rst_empty", bus.out_empty, 1);
        check("async_rst_next_free", bus.out_next_free_index, 0);
        check("async_rst_commit", bus.out_commit_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        repeat (200) rand_cycle();

`ifdef ROB_FLUSH_EN
        while (q.size() > 0) rand_cycle();
        repeat (5) alloc_gpr(9);
        cycle(1, 1, 3, 1, 0, 0, '0, '0, 0, 0, 1);
        check("flush_count", bus.out_count, 0);
        check("flush_empty", bus.out_empty, 1);
        check("flush_next_free", bus.out_next_free_index, 0);
        check("flush_commit", bus.out_commit_valid, 0);
        repeat (100) rand_cycle();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/rob_commit.md
# rob_commit

Reorder buffer and in-order commit stage of the Tomasulo core. Dispatch allocates one entry per instruction and receives its ROB tag. Functional units complete out of order over a single writeback bus. Entries retire strictly in program order: the destination value and NZCV flags go to the regfile, and the freed tag becomes available again.

## Interface
Parameters:
- ROB_SIZE, default 18 (2*RS_SIZE+2): number of entries; need not be a power of two.
- REG_SIZE, default 64: data width.
- GPR_COUNT, default 32: architectural registers.

Ports (IDX = clog2(ROB_SIZE), GIDX = clog2(GPR_COUNT)):
- in_clk  in  1  sole clock, rising edge.
- in_rst_n  in  1  asynchronous, active-low reset.
- in_alloc_valid  in  1  dispatch requests an entry.
- in_alloc_writes_gpr  in  1  instruction has a GPR destination.
- in_alloc_gpr_idx  in  GIDX  destination GPR.
- in_alloc_set_nzcv  in  1  instruction writes flags.
- out_alloc_ready  out  1  an entry is free.
- out_next_free_index  out  IDX  tag given to this cycle's allocation (tail).
- in_wb_valid  in  1  writeback bus valid.
- in_wb_rob_index  in  IDX  completing tag.
- in_wb_value  in  REG_SIZE  result.
- in_wb_nzcv  in  4  flags result.
- in_rd{1,2}_index  in  IDX  operand lookups from dispatch.
- out_rd{1,2}_ready  out  1  that entry is done.
- out_rd{1,2}_value  out  REG_SIZE  that entry's value.
- out_commit_valid  out  1  one retirement this cycle.
- out_commit_rob_index  out  IDX  retired tag.
- out_commit_writes_gpr  out  1  regfile write enable.
- out_commit_gpr_idx  out  GIDX  regfile write index.
- out_commit_value  out  REG_SIZE  value to commit.
- out_commit_set_nzcv  out  1  flags write enable.
- out_commit_nzcv  out  4  flags to commit.
- out_count  out  IDX+1  occupied entries.
- out_empty, out_full  out  1  count==0, count==ROB_SIZE.
- in_flush  in  1  present only with ROB_FLUSH_EN.

## Operation
- Circular buffer with head (oldest) and tail (next free) pointers plus a count. Pointers increment modulo ROB_SIZE: at ROB_SIZE-1 the next value is 0, with no power-of-two masking.
- Each entry holds valid, done, writes_gpr, gpr_idx, set_nzcv, value and nzcv.
- Allocate: in_alloc_valid && out_alloc_ready writes tail with valid=1, done=0, then tail++. Requests made while full are dropped and have no effect.
- Writeback: in_wb_valid on a valid, not-done entry sets done=1 and stores value and nzcv. Writeback to an invalid or already-done entry is ignored.
- Commit: if the head entry is valid and done at a rising edge, its fields are registered onto the out_commit_* outputs with out_commit_valid=1, the entry is cleared, and head++. At most one commit per cycle. Otherwise out_commit_valid=0.
- Read ports are combinational over the stored state. If in_wb_valid matches rdN_index on a valid entry, the read returns ready=1 and in_wb_value (same-cycle forwarding). An invalid entry reads as ready=0 and value=0.
- Allocate, writeback and commit in the same cycle are all performed. count' = count + alloc − commit.

## Timing
- Reset values: all entries invalid, head=tail=0, count=0, out_commit_* all 0, out_alloc_ready=1, out_empty=1, out_full=0, out_next_free_index=0.
- out_alloc_ready, out_full and out_empty depend only on the registered count. A commit in the same cycle does not free a slot for an allocation in that cycle.
- Writeback at edge N lets that entry commit at edge N+1 at the earliest, provided it is at the head. out_commit_* are valid for exactly one cycle.
- A commit on a full ROB deasserts out_full in the following cycle.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.

## Configuration
- ROB_FLUSH_EN defined: the in_flush port exists. When in_flush is high at an edge:
  - all entries are invalidated, head=tail=0 and count=0;
  - out_commit_valid=0 in the next cycle;
  - flush overrides any same-cycle allocate, writeback or commit.
- ROB_FLUSH_EN undefined: the port and its logic are absent. Only reset clears the buffer.

## Structure
- Shared package holds:
  - the ROB_SIZE, ROB_IDX_SIZE, REG_SIZE, GPR_COUNT and GPR_IDX_SIZE constants;
  - the rob_entry typedef (valid, done, writes_gpr, gpr_idx[GIDX], value[REG_SIZE], nzcv[4], set_nzcv);
  - the commit-bus struct.
- One sub-module, rob_ptr: a modulo-ROB_SIZE pointer register with increment and clear, instantiated for head and tail.

## Test plan
- Reset, then allocate 3 entries (gpr 1,2,3) → tags 0,1,2; out_count=3; out_commit_valid stays 0.
- Writeback tag 2 (value 0x22), then tag 0 (0x11) → tag 0 commits at the edge after its writeback (gpr 1, 0x11). Tag 1 blocks tag 2 until tag 1 writes back (0x33) → commits follow in the order 1, 2.
- Allocate 18 entries → out_full=1, out_alloc_ready=0; a 19th request is dropped and count stays 18.
- Long run of allocate+writeback+commit → tail wraps from 17 to 0; tags repeat correctly and out_count stays steady.
- Writeback of tag 4 with rd1_index=4 in the same cycle → out_rd1_ready=1 and out_rd1_value=in_wb_value combinationally.
- With ROB_FLUSH_EN: flush asserted with 5 entries in flight plus a same-cycle allocate → next cycle count=0, out_empty=1, out_next_free_index=0, no commit.
